mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Control FSM that sequences one fully-connected MLP layer on a single shared MAC datapath.
//  For each of M neurons it: clears the accumulator, steps N weight/input products, adds the
//  bias, applies the activation and writes the result word. Sits inside top between the
//  init/ready interface and the weight ROM + MAC/activation datapath.
// PARAMETERS
//  N          1   inputs per neuron (MAC steps per neuron), >=1
//  M          1   neurons in the layer (output words), >=1
//  IDX_W      derived  max(1,$clog2(N)), width of input index
//  NEU_W      derived  max(1,$clog2(M)), width of neuron index
//  ADDR_W     derived  max(1,$clog2(M*(N+1))), weight ROM address width
// PORTS
//  clk       in   1       clock, all state changes on rising edge
//  n_rst     in   1       asynchronous active-low reset
//  init      in   1       level request: run layer while high; low aborts/acknowledges
//  w_addr    out  ADDR_W  weight ROM address; row-major, neuron j: j*(N+1)+i, bias j*(N+1)+N
//  in_sel    out  IDX_W   index of inputs[] word feeding MAC this cycle
//  acc_clr   out  1       clear accumulator (1 cycle per neuron)
//  acc_en    out  1       accumulate w*x this cycle
//  bias_en   out  1       accumulate bias word this cycle
//  act_en    out  1       register activation(acc) this cycle
//  out_we    out  1       write activated word to outputs[out_idx]
//  out_idx   out  NEU_W   neuron index being written
//  busy      out  1       high in any state except IDLE and DONE
//  ready     out  1       high in DONE: all M outputs valid
// BEHAVIOUR
//  Reset (n_rst=0, async): state=IDLE, all counters 0, every output 0.
//  States: IDLE, CLEAR, MAC, BIAS, ACT, WRITE, DONE. All outputs are Moore (decoded from
//   registered state/counters), no combinational path from init.
//  IDLE : init=1 -> CLEAR (neuron j=0, i=0); else stay.
//  CLEAR: acc_clr=1, w_addr=j*(N+1) prefetched -> MAC.
//  MAC  : acc_en=1, in_sel=i, w_addr=j*(N+1)+i; i==N-1 -> BIAS (i:=0), else i++.
//  BIAS : bias_en=1, w_addr=j*(N+1)+N -> ACT.
//  ACT  : act_en=1 -> WRITE.
//  WRITE: out_we=1, out_idx=j; j==M-1 -> DONE, else j++ and -> CLEAR.
//  DONE : ready=1, held while init=1; init=0 -> IDLE (ready drops next cycle).
//  Timing: N+4 cycles per neuron; first DONE cycle is exactly M*(N+4) cycles after the first
//   CLEAR cycle. N=1,M=1: 5 busy cycles.
//  Abort: init=0 in any busy state -> IDLE next edge; counters zeroed, no further out_we.
//   Partial outputs are not valid; ready never asserts for an aborted run.
//  Re-run: init held high across DONE does NOT restart; a new run needs init low >=1 cycle.
//  Outside their states w_addr/in_sel/out_idx drive 0; exactly one strobe
//   (acc_clr/acc_en/bias_en/act_en/out_we) is high in each busy state, none in IDLE/DONE.
//  Counters never wrap: i bounded by N-1, j by M-1; N=1/M=1 terminal immediately.
//  Reset asserted mid-run: immediate IDLE, all outputs 0, no out_we glitch.
// STRUCTURE
//  Package mlp_pkg: seq_state_t enum {IDLE,CLEAR,MAC,BIAS,ACT,WRITE,DONE}; function
//   clog2_min1(int); shared WORD_SIZE default and weight-row layout constant (N+1 per neuron).
//  Sub-module mlp_idx_counter #(MAX,W): clr, inc, q, last (q==MAX-1); instanced twice
//   (input index i, neuron index j). Address formed as j*(N+1)+offset with registered base.
// TESTING
//  N=1,M=1, init rises after reset -> CLEAR,MAC,BIAS,ACT,WRITE then ready=1 on 6th edge;
//   w_addr sequence 0,0,1; out_we once with out_idx=0.
//  N=3,M=2 -> 14 busy cycles; MAC w_addr 0,1,2 / 4,5,6; bias 3 and 7; out_idx 0 then 1.
//  N=3,M=2, drop init during 2nd MAC of neuron 1 -> IDLE next edge, no more out_we, ready=0.
//  Hold init=1 after DONE for 10 cycles -> ready stays 1, no restart; init low 1 cycle then
//   high -> full new run with identical strobe trace.
//  Assert n_rst=0 mid-WRITE (async, off clock edge) -> all outputs 0 immediately, IDLE.
//  Assertion: onehot0 of the five strobes every cycle; busy & ready never both high.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and sizing helpers for the MLP layer sequencer slice.
// Holds the state encoding, width helpers and the weight-row layout (N weights + 1 bias).
package mlp_pkg;

  localparam int WORD_SIZE = 16;
  // Each neuron's row holds its N weights followed by one bias word.
  localparam int ROW_EXTRA = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    BIAS,
    ACT,
    WRITE,
    DONE
  } seq_state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int row_len(input int n);
    return n + ROW_EXTRA;
  endfunction

endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// Control bundle between the layer sequencer (master) and the ROM/MAC/activation datapath (slave).
// Widths derive from the layer shape N x M.
interface mlp_layer_sequencer_if #(
  parameter int N = 1,
  parameter int M = 1
);
  localparam int IDX_W  = mlp_pkg::clog2_min1(N);
  localparam int NEU_W  = mlp_pkg::clog2_min1(M);
  localparam int ADDR_W = mlp_pkg::clog2_min1(M * mlp_pkg::row_len(N));

  logic              init;
  logic [ADDR_W-1:0] w_addr;
  logic [IDX_W-1:0]  in_sel;
  logic              acc_clr;
  logic              acc_en;
  logic              bias_en;
  logic              act_en;
  logic              out_we;
  logic [NEU_W-1:0]  out_idx;
  logic              busy;
  logic              ready;

  modport master (
    input  init,
    output w_addr, in_sel, acc_clr, acc_en, bias_en, act_en, out_we, out_idx, busy, ready
  );

  modport slave (
    output init,
    input  w_addr, in_sel, acc_clr, acc_en, bias_en, act_en, out_we, out_idx, busy, ready
  );

endinterface

// File: rtl/mlp_idx_counter.sv
// Bounded up-counter (0..MAX-1) that saturates at MAX-1; clr has priority over inc.
// One-cycle update latency; last is a pure decode of the registered count.
module mlp_idx_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         last
);

  assign last = (q == W'(MAX - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !last) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Sequences one fully-connected layer (M neurons x N inputs) on a shared MAC: clear, N MACs, bias, act, write.
// N+4 cycles per neuron, all outputs registered; init is a level request, dropping it aborts any busy state.
module mlp_layer_sequencer import mlp_pkg::*; #(
  parameter int N = 1,
  parameter int M = 1
) (
  input logic                   clk,
  input logic                   n_rst,
  mlp_layer_sequencer_if.master sq
);

  localparam int IDX_W  = clog2_min1(N);
  localparam int NEU_W  = clog2_min1(M);
  localparam int ADDR_W = clog2_min1(M * row_len(N));
  localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(row_len(N));
  localparam logic [ADDR_W-1:0] BIAS_A = ADDR_W'(N);

  seq_state_t        state;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  i_q;
  logic [NEU_W-1:0]  j_q;
  logic              i_last, j_last;
  logic              i_clr, i_inc, j_clr, j_inc;
  logic              in_run;

  assign in_run = (state inside {CLEAR, MAC, BIAS, ACT, WRITE});

  // i walks the MAC steps of the current neuron and restarts for every neuron.
  assign i_inc = (state == MAC);
  assign i_clr = (state != MAC) || !sq.init || i_last;
  // j survives across neurons; only idle/done or an abort zeroes it.
  assign j_inc = (state == WRITE);
  assign j_clr = !in_run || !sq.init;

  mlp_idx_counter #(.MAX(N), .W(IDX_W)) u_i_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (i_clr),
    .inc   (i_inc),
    .q     (i_q),
    .last  (i_last)
  );

  mlp_idx_counter #(.MAX(M), .W(NEU_W)) u_j_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (j_clr),
    .inc   (j_inc),
    .q     (j_q),
    .last  (j_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      base       <= '0;
      sq.w_addr  <= '0;
      sq.in_sel  <= '0;
      sq.out_idx <= '0;
      sq.acc_clr <= 1'b0;
      sq.acc_en  <= 1'b0;
      sq.bias_en <= 1'b0;
      sq.act_en  <= 1'b0;
      sq.out_we  <= 1'b0;
      sq.busy    <= 1'b0;
      sq.ready   <= 1'b0;
    end else begin
      sq.w_addr  <= '0;
      sq.in_sel  <= '0;
      sq.out_idx <= '0;
      sq.acc_clr <= 1'b0;
      sq.acc_en  <= 1'b0;
      sq.bias_en <= 1'b0;
      sq.act_en  <= 1'b0;
      sq.out_we  <= 1'b0;
      sq.busy    <= 1'b0;
      sq.ready   <= 1'b0;
      if (in_run && !sq.init) begin
        state <= IDLE;
        base  <= '0;
      end else begin
        case (state)
          IDLE: begin
            base <= '0;
            if (sq.init) begin
              state      <= CLEAR;
              sq.acc_clr <= 1'b1;
              sq.busy    <= 1'b1;
            end
          end
          CLEAR: begin
            state     <= MAC;
            sq.acc_en <= 1'b1;
            sq.w_addr <= base;
            sq.busy   <= 1'b1;
          end
          MAC: begin
            sq.busy <= 1'b1;
            if (i_last) begin
              state      <= BIAS;
              sq.bias_en <= 1'b1;
              sq.w_addr  <= base + BIAS_A;
            end else begin
              sq.acc_en <= 1'b1;
              sq.in_sel <= i_q + 1'b1;
              sq.w_addr <= base + ADDR_W'(i_q) + ADDR_W'(1);
            end
          end
          BIAS: begin
            state     <= ACT;
            sq.act_en <= 1'b1;
            sq.busy   <= 1'b1;
          end
          ACT: begin
            state      <= WRITE;
            sq.out_we  <= 1'b1;
            sq.out_idx <= j_q;
            sq.busy    <= 1'b1;
          end
          WRITE: begin
            if (j_last) begin
              state    <= DONE;
              sq.ready <= 1'b1;
            end else begin
              // Advance to the next weight row; the CLEAR cycle already prefetches its first word.
              state      <= CLEAR;
              base       <= base + ROW_A;
              sq.w_addr  <= base + ROW_A;
              sq.acc_clr <= 1'b1;
              sq.busy    <= 1'b1;
            end
          end
          DONE: begin
            if (sq.init) begin
              sq.ready <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  a_strobe_onehot0: assert property (@(posedge clk) disable iff (!n_rst)
    $onehot0({sq.acc_clr, sq.acc_en, sq.bias_en, sq.act_en, sq.out_we}));
  a_busy_ready_excl: assert property (@(posedge clk) disable iff (!n_rst)
    !(sq.busy && sq.ready));

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: vector table on an N=1,M=1 instance, directed corner cases
// and random init traffic on an N=3,M=2 instance checked against a schedule-level model.
module tb_mlp_layer_sequencer;

  localparam int NB = 3;
  localparam int MB = 2;

  typedef struct packed {
    logic       acc_clr;
    logic       acc_en;
    logic       bias_en;
    logic       act_en;
    logic       out_we;
    logic       busy;
    logic       ready;
    logic [7:0] w_addr;
    logic [7:0] in_sel;
    logic [7:0] out_idx;
  } obs_t;

  typedef struct {
    logic init;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mlp_layer_sequencer_if #(.N(1), .M(1)) ia ();
  mlp_layer_sequencer_if #(.N(NB), .M(MB)) ib ();

  mlp_layer_sequencer #(.N(1), .M(1)) dut_a (.clk(clk), .n_rst(n_rst), .sq(ia));
  mlp_layer_sequencer #(.N(NB), .M(MB)) dut_b (.clk(clk), .n_rst(n_rst), .sq(ib));

  function automatic obs_t mk(input logic c, e, b, a, w, bz, rd, input int wa, is, oi);
    obs_t o;
    o.acc_clr = c;  o.acc_en = e;  o.bias_en = b;  o.act_en = a;  o.out_we = w;
    o.busy = bz;    o.ready = rd;
    o.w_addr = 8'(wa);  o.in_sel = 8'(is);  o.out_idx = 8'(oi);
    return o;
  endfunction

  function automatic obs_t obs_a();
    return mk(ia.acc_clr, ia.acc_en, ia.bias_en, ia.act_en, ia.out_we, ia.busy, ia.ready,
              int'(ia.w_addr), int'(ia.in_sel), int'(ia.out_idx));
  endfunction

  function automatic obs_t obs_b();
    return mk(ib.acc_clr, ib.acc_en, ib.bias_en, ib.act_en, ib.out_we, ib.busy, ib.ready,
              int'(ib.w_addr), int'(ib.in_sel), int'(ib.out_idx));
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: a run is the flat list of busy cycles the layer must produce.
  obs_t sched[$];
  obs_t cur;
  int   mode = 0;  // 0 idle, 1 running, 2 done
  obs_t trace_q[$];

  task automatic build_schedule();
    sched.delete();
    for (int j = 0; j < MB; j++) begin
      sched.push_back(mk(1, 0, 0, 0, 0, 1, 0, j * (NB + 1), 0, 0));
      for (int i = 0; i < NB; i++)
        sched.push_back(mk(0, 1, 0, 0, 0, 1, 0, j * (NB + 1) + i, i, 0));
      sched.push_back(mk(0, 0, 1, 0, 0, 1, 0, j * (NB + 1) + NB, 0, 0));
      sched.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      sched.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, j));
    end
  endtask

  task automatic model_step();
    if (!n_rst) begin
      sched.delete();
      cur = '0;
      mode = 0;
    end else begin
      case (mode)
        0: if (ib.init) begin
             build_schedule();
             cur = sched.pop_front();
             mode = 1;
           end else cur = '0;
        1: if (!ib.init) begin
             sched.delete();
             cur = '0;
             mode = 0;
           end else if (sched.size() == 0) begin
             cur = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
             mode = 2;
           end else cur = sched.pop_front();
        default: if (!ib.init) begin
             cur = '0;
             mode = 0;
           end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_b", 64'(obs_b()), 64'(cur));
    if (ib.busy) trace_q.push_back(obs_b());
  endtask

  task automatic run_to_done(output int busy_cnt);
    bit got_ready;
    trace_q.delete();
    ib.init = 1'b1;
    busy_cnt = 0;
    got_ready = 1'b0;
    for (int k = 0; k < 60 && !got_ready; k++) begin
      cycle();
      if (ib.busy) busy_cnt++;
      if (ib.ready) got_ready = 1'b1;
    end
    check("run_reaches_ready", 64'(got_ready), 64'(1));
  endtask

  vec_t vecs[14];
  obs_t trace1[$];

  initial begin
    int bc;
    int cnt_rdy, cnt_busy, cnt_clr, cnt_we, diffs;
    logic [63:0] mac_v, in_v, bias_v, idx_v;
    bit found;

    vecs[0]  = '{1'b1, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[1]  = '{1'b1, mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[2]  = '{1'b1, mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 0)};
    vecs[3]  = '{1'b1, mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0)};
    vecs[4]  = '{1'b1, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[5]  = '{1'b1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    vecs[6]  = '{1'b1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    vecs[7]  = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[8]  = '{1'b1, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[9]  = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{1'b1, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[11] = '{1'b1, mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[12] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[13] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    n_rst = 1'b0;
    ia.init = 1'b0;
    ib.init = 1'b0;
    cur = '0;
    repeat (2) @(negedge clk);
    check("reset_a", 64'(obs_a()), 64'(0));
    check("reset_b", 64'(obs_b()), 64'(0));
    n_rst = 1'b1;
    cycle();

    // N=1, M=1 instance: vector table, one driven init per edge.
    for (int k = 0; k < 14; k++) begin
      ia.init = vecs[k].init;
      cycle();
      check($sformatf("vec_a[%0d]", k), 64'(obs_a()), 64'(vecs[k].exp));
    end

    // N=3, M=2 full run.
    run_to_done(bc);
    check("busy_cycles", 64'(bc), 64'(14));
    mac_v = '0; in_v = '0; bias_v = '0; idx_v = '0; cnt_we = 0;
    foreach (trace_q[k]) begin
      if (trace_q[k].acc_en) begin
        mac_v = (mac_v << 8) | 64'(trace_q[k].w_addr);
        in_v  = (in_v << 8) | 64'(trace_q[k].in_sel);
      end
      if (trace_q[k].bias_en) bias_v = (bias_v << 8) | 64'(trace_q[k].w_addr);
      if (trace_q[k].out_we) begin
        idx_v = (idx_v << 8) | 64'(trace_q[k].out_idx);
        cnt_we++;
      end
    end
    check("mac_addrs", mac_v, 64'h0000_0001_0204_0506);
    check("mac_in_sel", in_v, 64'h0000_0001_0200_0102);
    check("bias_addrs", bias_v, 64'h0307);
    check("out_we_count", 64'(cnt_we), 64'(2));
    check("out_idx_seq", idx_v, 64'h0001);
    trace1 = trace_q;

    // Holding init across DONE must not restart the layer.
    cnt_rdy = 0; cnt_busy = 0; cnt_clr = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (ib.ready) cnt_rdy++;
      if (ib.busy) cnt_busy++;
      if (ib.acc_clr) cnt_clr++;
    end
    check("hold_ready", 64'(cnt_rdy), 64'(10));
    check("hold_no_restart", 64'(cnt_busy + cnt_clr), 64'(0));
    ib.init = 1'b0;
    cycle();
    check("ack_idle", 64'(obs_b()), 64'(0));
    run_to_done(bc);
    diffs = 0;
    foreach (trace_q[k]) if (k < trace1.size() && trace_q[k] !== trace1[k]) diffs++;
    check("rerun_len", 64'(trace_q.size()), 64'(trace1.size()));
    check("rerun_trace", 64'(diffs), 64'(0));
    ib.init = 1'b0;
    cycle();

    // Abort during the second MAC of neuron 1 (w_addr 5).
    ib.init = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (ib.acc_en && ib.w_addr == 3'd5) found = 1'b1;
    end
    check("abort_point_found", 64'(found), 64'(1));
    ib.init = 1'b0;
    cycle();
    check("abort_idle", 64'(obs_b()), 64'(0));
    cnt_we = 0; cnt_rdy = 0; cnt_busy = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (ib.out_we) cnt_we++;
      if (ib.ready) cnt_rdy++;
      if (ib.busy) cnt_busy++;
    end
    check("abort_quiet", 64'(cnt_we + cnt_rdy + cnt_busy), 64'(0));

    // Random init traffic, mostly high so runs complete as well as abort.
    for (int k = 0; k < 400; k++) begin
      ib.init = ($urandom_range(0, 99) < 88);
      cycle();
    end
    ib.init = 1'b0;
    cycle();
    cycle();

    // Asynchronous reset in the middle of a WRITE cycle.
    ib.init = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (ib.out_we) found = 1'b1;
    end
    check("write_found", 64'(found), 64'(1));
    #2 n_rst = 1'b0;
    #1;
    check("async_reset_b", 64'(obs_b()), 64'(0));
    check("async_reset_a", 64'(obs_a()), 64'(0));
    ib.init = 1'b0;
    cycle();
    n_rst = 1'b1;
    repeat (3) cycle();
    check("post_reset_idle", 64'(obs_b()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
